// File: rtl/seg7_pkg.sv
// seg7_pkg: shared 7-segment definitions.
//   seg_t          : segment vector {g,f,e,d,c,b,a}, active-high.
//   SEG_0..SEG_F   : glyphs for codes 0-15 (A,b,C,d,E,F for 10-15).
//   SEG_OFF        : all segments dark.
//   seg7_decode_fn : value + hex enable -> segments; codes 10-15 go dark
//                    when hex is disabled, so BCD displays never show letters.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0   = 7'h3F;
  localparam seg_t SEG_1   = 7'h06;
  localparam seg_t SEG_2   = 7'h5B;
  localparam seg_t SEG_3   = 7'h4F;
  localparam seg_t SEG_4   = 7'h66;
  localparam seg_t SEG_5   = 7'h6D;
  localparam seg_t SEG_6   = 7'h7D;
  localparam seg_t SEG_7   = 7'h07;
  localparam seg_t SEG_8   = 7'h7F;
  localparam seg_t SEG_9   = 7'h6F;
  localparam seg_t SEG_A   = 7'h77;
  localparam seg_t SEG_B   = 7'h7C;
  localparam seg_t SEG_C   = 7'h39;
  localparam seg_t SEG_D   = 7'h5E;
  localparam seg_t SEG_E   = 7'h79;
  localparam seg_t SEG_F   = 7'h71;
  localparam seg_t SEG_OFF = 7'h00;

  function automatic seg_t seg7_decode_fn(input logic [3:0] value, input logic hex_en);
    seg_t seg;
    case (value)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'hA:    seg = hex_en ? SEG_A : SEG_OFF;
      4'hB:    seg = hex_en ? SEG_B : SEG_OFF;
      4'hC:    seg = hex_en ? SEG_C : SEG_OFF;
      4'hD:    seg = hex_en ? SEG_D : SEG_OFF;
      4'hE:    seg = hex_en ? SEG_E : SEG_OFF;
      default: seg = hex_en ? SEG_F : SEG_OFF;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational nibble-to-segment decoder with a blank override.
//   value  : 4-bit digit code
//   hex_en : 1 shows A-F for codes 10-15, 0 darkens them
//   blank  : forces all segments dark (leading-zero suppression)
//   seg    : segments {g,f,e,d,c,b,a}, active-high
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] value,
  input  logic       hex_en,
  input  logic       blank,
  output seg_t       seg
);

  always_comb begin
    seg = blank ? SEG_OFF : seg7_decode_fn(value, hex_en);
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed DIGITS-wide 7-segment display scanner.
//   Clk, Rst : clock and synchronous active-high reset
//   Load     : strobe capturing Data/Dp_in into the shadow buffer
//   Data     : nibble i drives digit i (digit 0 least significant)
//   Dp_in    : decimal point per digit
//   Hex_en   : live select of hex glyphs for codes 10-15
//   Lz_en    : live leading-zero blanking enable
//   S, Dp    : registered segment and decimal-point pins, active-high
//   Com      : registered digit enables, polarity from COM_ACTIVE_LOW
//   Frame    : one-cycle pulse after the last digit slot of a frame ends
// Each digit slot is DIV cycles: DEAD blank cycles (ghosting guard) then
// DIV-DEAD drive cycles. New data reaches the displayed buffer only at the
// frame wrap, so a frame never mixes old and new digits.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int DIV            = 50000,
  parameter int DEAD           = 16,
  parameter bit COM_ACTIVE_LOW = 1'b1
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Load,
  input  logic [4*DIGITS-1:0]   Data,
  input  logic [DIGITS-1:0]     Dp_in,
  input  logic                  Hex_en,
  input  logic                  Lz_en,
  output logic [6:0]            S,
  output logic                  Dp,
  output logic [DIGITS-1:0]     Com,
  output logic                  Frame
);

  localparam int CNT_W = $clog2(DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_DRIVE = 1'b1;
  // With no dead time every slot starts directly in DRIVE.
  localparam logic [0:0] ST_SLOT_START = (DEAD == 0) ? ST_DRIVE : ST_BLANK;

  localparam logic [CNT_W-1:0]  CNT_LAST      = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_DEAD_LAST = CNT_W'(DEAD - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST      = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] COM_OFF       = {DIGITS{COM_ACTIVE_LOW}};

  logic [0:0]          state;
  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;

  logic [4*DIGITS-1:0] shadow_data, active_data;
  logic [DIGITS-1:0]   shadow_dp, active_dp;
  logic                pending;

  logic                slot_end, wrap;
  logic [3:0]          cur_value;
  logic                cur_dp;
  logic                upper_zero;
  logic                lz_blank;
  logic [DIGITS-1:0]   onehot;
  seg_t                dec_seg;

  assign slot_end = (state == ST_DRIVE) && (cnt == CNT_LAST);
  assign wrap     = slot_end && (idx == IDX_LAST);

  // Slot timing: counter, BLANK/DRIVE state and digit index.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= ST_SLOT_START;
      cnt   <= '0;
      idx   <= '0;
    end else if (slot_end) begin
      cnt   <= '0;
      state <= ST_SLOT_START;
      idx   <= wrap ? '0 : idx + IDX_W'(1);
    end else begin
      cnt <= cnt + CNT_W'(1);
      if (state == ST_BLANK && cnt == CNT_DEAD_LAST) state <= ST_DRIVE;
    end
  end

  // Double buffer. A Load on the wrap cycle goes straight to the active
  // buffer so the newest value is shown without a one-frame delay.
  // NOTE: the buffers are reset explicitly because the display must come
  // up showing zeros, not power-on garbage.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      shadow_data <= '0;
      shadow_dp   <= '0;
      active_data <= '0;
      active_dp   <= '0;
      pending     <= 1'b0;
    end else if (wrap) begin
      if (Load) begin
        active_data <= Data;
        active_dp   <= Dp_in;
        shadow_data <= Data;
        shadow_dp   <= Dp_in;
      end else if (pending) begin
        active_data <= shadow_data;
        active_dp   <= shadow_dp;
      end
      pending <= 1'b0;
    end else if (Load) begin
      shadow_data <= Data;
      shadow_dp   <= Dp_in;
      pending     <= 1'b1;
    end
  end

  // Digit select plus "this digit and all higher digits are zero" test.
  // NOTE: every output is given a default first so no latch is inferred.
  always_comb begin
    cur_value  = 4'h0;
    cur_dp     = 1'b0;
    upper_zero = 1'b1;
    onehot     = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_value = active_data[4*i +: 4];
        cur_dp    = active_dp[i];
        onehot[i] = 1'b1;
      end
      if (i >= int'(idx) && active_data[4*i +: 4] != 4'h0) upper_zero = 1'b0;
    end
  end

  // Digit 0 is never suppressed so a zero value still shows "0".
  assign lz_blank = Lz_en && (idx != '0) && upper_zero;

  seg7_decode u_decode (
    .value  (cur_value),
    .hex_en (Hex_en),
    .blank  (lz_blank),
    .seg    (dec_seg)
  );

  // Registered pins: one cycle behind the state/index that produced them.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      S     <= SEG_OFF;
      Dp    <= 1'b0;
      Com   <= COM_OFF;
      Frame <= 1'b0;
    end else begin
      Frame <= wrap;
      if (state == ST_DRIVE) begin
        S   <= dec_seg;
        Dp  <= cur_dp;
        Com <= onehot ^ COM_OFF;
      end else begin
        S   <= SEG_OFF;
        Dp  <= 1'b0;
        Com <= COM_OFF;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: scoreboard bench for seg7_scan_driver
// (DIGITS=4, DIV=8, DEAD=2, active-low Com). The driver pushes the expected
// pin state for every clock it drives; a monitor pops and compares after
// each edge. Expectations come from a timeline model: cycle position within
// the frame picks digit/phase, and the displayed value is whatever was
// loaded most recently as of the last frame boundary.
module tb_seg7_scan_driver;

  localparam int DIGITS    = 4;
  localparam int DIV       = 8;
  localparam int DEAD      = 2;
  localparam int FRAME_LEN = DIGITS * DIV;

  logic        clk = 1'b0;
  logic        rst, load, hex_en, lz_en;
  logic [15:0] data;
  logic [3:0]  dp_in;
  logic [6:0]  s;
  logic        dp;
  logic [3:0]  com;
  logic        frame;

  seg7_scan_driver #(
    .DIGITS(DIGITS), .DIV(DIV), .DEAD(DEAD), .COM_ACTIVE_LOW(1'b1)
  ) dut (
    .Clk(clk), .Rst(rst), .Load(load), .Data(data), .Dp_in(dp_in),
    .Hex_en(hex_en), .Lz_en(lz_en), .S(s), .Dp(dp), .Com(com), .Frame(frame)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] com;
    logic [6:0] s;
    logic       dp;
    logic       frame;
  } pins_t;

  pins_t exp_q[$];
  pins_t mon_e;
  int    checks   = 0;
  int    failures = 0;

  logic [6:0] seg_table [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model state.
  int          k;
  logic [15:0] latest_data, shown_data;
  logic [3:0]  latest_dp, shown_dp;
  logic        cur_hex, cur_lz;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic pins_t model_pins(input int pos, input logic [15:0] d, input logic [3:0] dps,
                                       input logic hx, input logic lz);
    pins_t      p;
    int         digit, phase;
    logic [3:0] nib;
    digit   = (pos / DIV) % DIGITS;
    phase   = pos % DIV;
    p.com   = 4'b1111;
    p.s     = 7'h00;
    p.dp    = 1'b0;
    p.frame = ((pos % FRAME_LEN) == FRAME_LEN - 1);
    if (phase >= DEAD) begin
      p.com[digit] = 1'b0;
      p.dp         = dps[digit];
      nib          = d[4*digit +: 4];
      if (lz && digit > 0 && (d >> (4 * digit)) == 16'h0) p.s = 7'h00;
      else if (nib > 4'd9 && !hx)                         p.s = 7'h00;
      else                                                p.s = seg_table[nib];
    end
    return p;
  endfunction

  // Drive one clock of inputs and push the pins expected after that edge.
  task automatic step(input logic r, input logic ld, input logic [15:0] d, input logic [3:0] dpv);
    pins_t e;
    @(negedge clk);
    rst = r; load = ld; data = d; dp_in = dpv; hex_en = cur_hex; lz_en = cur_lz;
    if (r) begin
      e = '{com: 4'hF, s: 7'h00, dp: 1'b0, frame: 1'b0};
      k = 0;
      latest_data = '0; latest_dp = '0; shown_data = '0; shown_dp = '0;
    end else begin
      e = model_pins(k, shown_data, shown_dp, cur_hex, cur_lz);
      if (ld) begin
        latest_data = d;
        latest_dp   = dpv;
      end
      if (e.frame) begin
        shown_data = latest_data;
        shown_dp   = latest_dp;
      end
      k++;
    end
    exp_q.push_back(e);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'($urandom), 4'($urandom));
  endtask

  task automatic run_to(input int pos);
    for (int i = 0; i < FRAME_LEN && (k % FRAME_LEN) != pos; i++) run(1);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dpv);
    step(1'b0, 1'b1, d, dpv);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'($urandom), 4'($urandom));
  endtask

  // Monitor: compare the oldest expectation once the pins have settled.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("com",   32'(com),   32'(mon_e.com));
      check("seg",   32'(s),     32'(mon_e.s));
      check("dp",    32'(dp),    32'(mon_e.dp));
      check("frame", 32'(frame), 32'(mon_e.frame));
    end
  end

  initial begin
    logic [15:0] masks [4] = '{16'h000F, 16'h00FF, 16'h0FFF, 16'hFFFF};
    cur_hex = 1'b1;
    cur_lz  = 1'b0;
    k = 0;

    // Reset, then scan the all-zero buffer.
    do_reset(3);
    run(40);

    // Mid-frame load holds off until the wrap.
    run_to(10);
    do_load(16'h1234, 4'b0100);
    run(80);

    // Hex glyphs on and off.
    do_load(16'h00AF, 4'b0000);
    run(70);
    cur_hex = 1'b0;
    run(40);
    cur_hex = 1'b1;

    // Leading-zero blanking.
    cur_lz = 1'b1;
    do_load(16'h0007, 4'b1000);
    run(70);
    do_load(16'h0000, 4'b0000);
    run(70);
    cur_lz = 1'b0;
    run(40);

    // Load exactly on the wrap cycle, plus multiple loads in one frame.
    run_to(FRAME_LEN - 1);
    do_load(16'h9999, 4'b0000);
    run(40);
    do_load(16'h1111, 4'b0001);
    run(5);
    do_load(16'h5678, 4'b0010);
    run(60);

    // Reset in the middle of digit 2's drive window.
    run_to(2 * DIV + 4);
    do_reset(1);
    run(45);

    // Randomized traffic.
    for (int i = 0; i < 700; i++) begin
      cur_hex = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) cur_lz = ~cur_lz;
      if ($urandom_range(0, 299) == 0)
        do_reset($urandom_range(1, 2));
      else if ($urandom_range(0, 5) == 0)
        do_load(16'($urandom) & masks[$urandom_range(0, 3)], 4'($urandom));
      else
        run(1);
    end

    @(posedge clk);
    #3;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
